mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the CPU's single 32-bit memory port between three requesters: instruction fetch (read), load unit (read) and store unit (write).
- Round-robin arbitration; requesters see a ready/req handshake, same as the memory side.
- Tracks outstanding reads in an in-order ID queue and routes returning read data to the originating requester.
- Sits between the CPU front/back ends and the system bus/memory interconnect.

Parameters:
- MAX_OUTSTANDING, 4, max accepted-but-unreturned reads; power of two, >=2.

Ports:
- clk  in  1  clock
- reset_n  in  1  synchronous active-low reset
- ifetch_read_req  in  1  fetch read request, held until accepted
- ifetch_read_addr  in  32  word-aligned fetch address
- ifetch_ready  out  1  fetch request accepted this cycle
- ifetch_read_data  out  32  returned fetch data
- ifetch_read_data_valid  out  1  fetch data valid
- load_read_req  in  1  load read request
- load_read_addr  in  32  word-aligned load address
- load_ready  out  1  load request accepted this cycle
- load_read_data  out  32  returned load data
- load_read_data_valid  out  1  load data valid
- store_write_req  in  1  store write request
- store_addr  in  32  word-aligned store address
- store_write_data  in  32  store data
- store_byte_enable  in  4  store byte lanes
- store_ready  out  1  store write accepted this cycle
- mem_ready  in  1  memory accepts current request
- mem_addr  out  32  muxed address
- mem_write_data  out  32  muxed write data
- mem_byte_enable  out  4  muxed byte enable; 4'hf for reads
- mem_read_req  out  1  read request
- mem_write_req  out  1  write request
- mem_read_data  in  32  read return data
- mem_read_data_valid  in  1  read return strobe, in request order
- error  out  1  sticky: read data returned with empty queue

Behaviour:
- Clock and reset: clk; reset_n synchronous, active-low.
- Reset values:
  - mem_read_req, mem_write_req, all *_ready and *_data_valid outputs, and error are 0 while reset_n=0.
  - mem_addr, mem_write_data and mem_byte_enable are 0 while reset_n=0.
  - Round-robin pointer resets to IFETCH; ID queue resets to empty.
- Eligibility:
  - Reads (fetch, load) are eligible only when their req=1 and the queue is not full.
  - Store is eligible when store_write_req=1.
- Grant:
  - Combinational each cycle: first eligible port at or after the pointer, in order IFETCH -> LOAD -> STORE -> wrap.
  - The winner's addr/data/byte enable and req drive the mem_* outputs.
  - With no winner, mem_read_req=mem_write_req=0 and the mem_* data outputs hold 0.
- Accept: a transfer is accepted when the winner's req=1 and mem_ready=1. Then:
  - The winner's *_ready=1 for that cycle; all other *_ready=0.
  - The pointer moves to the port after the winner on the next clk.
  - On a read, the winner ID is pushed into the queue.
  - With no accept, the pointer holds; grant may change between cycles if requests change.
- Zero added latency: the request path is combinational; the pointer and queue are registered.
- Read return:
  - On mem_read_data_valid=1, pop the queue head.
  - Drive the matching *_read_data_valid=1 the same cycle, combinationally; mem_read_data fans out to both read data outputs.
- Simultaneous push and pop: count unchanged; pop returns the old head.
- Full queue (MAX_OUTSTANDING in flight): no read is granted; a store can still win.
  - A pop in the same cycle does NOT free a slot for a push; eligibility uses registered fullness.
- Empty queue with mem_read_data_valid=1: no valid is forwarded; error is set and stays set until reset.
- Store split halves: the store unit's two word writes are arbitrated independently; a load or fetch may interleave between them. Memory is in-order, so no ordering hazard arises.
- Reset mid-operation: queue cleared; read data still in flight after reset is discarded and sets error. The system resets memory together with the CPU.

Decomposition:
- Shared package cpu_mem_pkg:
  - port_id_t typedef (2-bit: IFETCH=0, LOAD=1, STORE=2);
  - the read-byte-enable constant 4'hf.
- Sub-module mem_id_fifo: synchronous FIFO of 1-bit read IDs.
  - Parameter DEPTH; ports push, push_id, pop, head_id, full, empty.
  - Wrap-around pointers plus a count register.

Test Plan:
- Single load at 0x100, mem_ready=1, data 0xdeadbeef returned 3 cycles later -> load_ready pulses in cycle 0; load_read_data_valid=1 with 0xdeadbeef; ifetch sees nothing.
- All three requesting continuously, mem_ready=1 -> grants IFETCH, LOAD, STORE, IFETCH... Each store cycle drives mem_write_req=1 with the store's byte enables.
- Fetch 0x0, then load 0x4, returned in order with data 0x11, 0x22 -> ifetch gets 0x11, load gets 0x22.
- Fetch and load requesting, no returns -> exactly 4 reads accepted. Read readies then stay 0 while a store_write_req is still accepted. One return -> the next read accepted the following cycle.
- mem_ready=0 for 5 cycles with all requesting -> no *_ready; pointer and mem_addr stable. Drop store_write_req -> grant moves to the next eligible port.
- mem_read_data_valid=1 with queue empty -> error=1 and stays 1; no *_read_data_valid. Assert reset_n=0 for one cycle -> error=0, queue empty, pointer back to IFETCH.

Source files
------------

// File: rtl/cpu_mem_pkg.sv
// Shared types for the CPU memory-port arbiter: requester IDs and read byte-enable.
package cpu_mem_pkg;

  typedef enum logic [1:0] {
    PORT_IFETCH = 2'd0,
    PORT_LOAD   = 2'd1,
    PORT_STORE  = 2'd2
  } port_id_t;

  localparam int NUM_PORTS = 3;
  localparam logic [3:0] READ_BYTE_ENABLE = 4'hf;

  // Round-robin successor, wrapping STORE back to IFETCH.
  function automatic port_id_t next_port(input port_id_t p);
    case (p)
      PORT_IFETCH: return PORT_LOAD;
      PORT_LOAD:   return PORT_STORE;
      default:     return PORT_IFETCH;
    endcase
  endfunction

endpackage

// File: rtl/mem_id_fifo.sv
// In-order queue of 1-bit read IDs (0 = fetch, 1 = load); registered full/empty.
// Push when full and pop when empty are ignored.
module mem_id_fifo #(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic push,
  input  logic push_id,
  input  logic pop,
  output logic head_id,
  output logic full,
  output logic empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  logic [DEPTH-1:0] ids_q, ids_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == CNT_FULL);
  assign empty   = (count_q == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head_id = ids_q[rd_ptr_q];

  always_comb begin
    ids_d    = ids_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      ids_d[wr_ptr_q] = push_id;
      wr_ptr_d        = wr_ptr_q + PTR_ONE;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ids_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      ids_q    <= ids_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port between fetch, load and store; zero-latency
// request path, reads tracked in an in-order ID queue, reads blocked while the queue is full.
module mem_port_arbiter
  import cpu_mem_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        ifetch_read_req,
  input  logic [31:0] ifetch_read_addr,
  output logic        ifetch_ready,
  output logic [31:0] ifetch_read_data,
  output logic        ifetch_read_data_valid,
  input  logic        load_read_req,
  input  logic [31:0] load_read_addr,
  output logic        load_ready,
  output logic [31:0] load_read_data,
  output logic        load_read_data_valid,
  input  logic        store_write_req,
  input  logic [31:0] store_addr,
  input  logic [31:0] store_write_data,
  input  logic [3:0]  store_byte_enable,
  output logic        store_ready,
  input  logic        mem_ready,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_write_data,
  output logic [3:0]  mem_byte_enable,
  output logic        mem_read_req,
  output logic        mem_write_req,
  input  logic [31:0] mem_read_data,
  input  logic        mem_read_data_valid,
  output logic        error
);

  port_id_t ptr_q, ptr_d;
  port_id_t grant_id;
  logic     grant_vld;
  logic     accept;
  logic [NUM_PORTS-1:0] elig;
  logic     error_q, error_d;
  logic     q_full, q_empty, q_head;
  logic     push, push_id, pop;

  // Eligibility uses the registered full flag, so a same-cycle pop never frees a slot.
  assign elig[PORT_IFETCH] = reset_n & ifetch_read_req & ~q_full;
  assign elig[PORT_LOAD]   = reset_n & load_read_req & ~q_full;
  assign elig[PORT_STORE]  = reset_n & store_write_req;

  always_comb begin
    port_id_t cand;
    grant_vld = 1'b0;
    grant_id  = PORT_IFETCH;
    cand      = ptr_q;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (!grant_vld && elig[cand]) begin
        grant_vld = 1'b1;
        grant_id  = cand;
      end
      cand = next_port(cand);
    end
  end

  always_comb begin
    mem_addr        = '0;
    mem_write_data  = '0;
    mem_byte_enable = '0;
    mem_read_req    = 1'b0;
    mem_write_req   = 1'b0;
    if (grant_vld) begin
      case (grant_id)
        PORT_IFETCH: begin
          mem_addr        = ifetch_read_addr;
          mem_byte_enable = READ_BYTE_ENABLE;
          mem_read_req    = 1'b1;
        end
        PORT_LOAD: begin
          mem_addr        = load_read_addr;
          mem_byte_enable = READ_BYTE_ENABLE;
          mem_read_req    = 1'b1;
        end
        default: begin
          mem_addr        = store_addr;
          mem_write_data  = store_write_data;
          mem_byte_enable = store_byte_enable;
          mem_write_req   = 1'b1;
        end
      endcase
    end
  end

  assign accept       = grant_vld & mem_ready;
  assign ifetch_ready = accept & (grant_id == PORT_IFETCH);
  assign load_ready   = accept & (grant_id == PORT_LOAD);
  assign store_ready  = accept & (grant_id == PORT_STORE);

  assign push    = accept & (grant_id != PORT_STORE);
  assign push_id = (grant_id == PORT_LOAD);
  assign pop     = reset_n & mem_read_data_valid & ~q_empty;

  assign ifetch_read_data       = mem_read_data;
  assign load_read_data         = mem_read_data;
  assign ifetch_read_data_valid = pop & ~q_head;
  assign load_read_data_valid   = pop & q_head;

  always_comb begin
    ptr_d   = accept ? next_port(grant_id) : ptr_q;
    error_d = error_q | (mem_read_data_valid & q_empty);
  end

  assign error = error_q & reset_n;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ptr_q   <= PORT_IFETCH;
      error_q <= 1'b0;
    end else begin
      ptr_q   <= ptr_d;
      error_q <= error_d;
    end
  end

  mem_id_fifo #(
    .DEPTH(MAX_OUTSTANDING)
  ) u_id_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (push),
    .push_id (push_id),
    .pop     (pop),
    .head_id (q_head),
    .full    (q_full),
    .empty   (q_empty)
  );

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus randomized traffic
// compared against a queue-based reference model.
module tb_mem_port_arbiter;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        ifetch_read_req, load_read_req, store_write_req;
  logic [31:0] ifetch_read_addr, load_read_addr, store_addr, store_write_data;
  logic [3:0]  store_byte_enable;
  logic        mem_ready, mem_read_data_valid;
  logic [31:0] mem_read_data;
  logic        ifetch_ready, load_ready, store_ready;
  logic [31:0] ifetch_read_data, load_read_data;
  logic        ifetch_read_data_valid, load_read_data_valid;
  logic [31:0] mem_addr, mem_write_data;
  logic [3:0]  mem_byte_enable;
  logic        mem_read_req, mem_write_req, error;

  always #5 clk = ~clk;

  mem_port_arbiter #(.MAX_OUTSTANDING(DEPTH)) dut (
    .clk(clk), .reset_n(reset_n),
    .ifetch_read_req(ifetch_read_req), .ifetch_read_addr(ifetch_read_addr),
    .ifetch_ready(ifetch_ready), .ifetch_read_data(ifetch_read_data),
    .ifetch_read_data_valid(ifetch_read_data_valid),
    .load_read_req(load_read_req), .load_read_addr(load_read_addr),
    .load_ready(load_ready), .load_read_data(load_read_data),
    .load_read_data_valid(load_read_data_valid),
    .store_write_req(store_write_req), .store_addr(store_addr),
    .store_write_data(store_write_data), .store_byte_enable(store_byte_enable),
    .store_ready(store_ready), .mem_ready(mem_ready),
    .mem_addr(mem_addr), .mem_write_data(mem_write_data),
    .mem_byte_enable(mem_byte_enable), .mem_read_req(mem_read_req),
    .mem_write_req(mem_write_req), .mem_read_data(mem_read_data),
    .mem_read_data_valid(mem_read_data_valid), .error(error)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: next-preferred port, queue of outstanding reader IDs, sticky error.
  int m_ptr;
  int m_q[$];
  bit m_err;
  int e_grant;
  bit e_accept, e_pop;
  int e_head;
  logic [139:0] exp_v;
  logic [139:0] obs;

  assign obs = {ifetch_ready, load_ready, store_ready, mem_read_req, mem_write_req,
                mem_addr, mem_write_data, mem_byte_enable,
                ifetch_read_data_valid, load_read_data_valid,
                ifetch_read_data, load_read_data, error};

  task automatic eval_model();
    bit full, el, rr, wr;
    int p;
    logic [31:0] a, wd;
    logic [3:0] be;
    full    = (m_q.size() >= DEPTH);
    e_grant = -1;
    if (reset_n) begin
      for (int i = 0; i < 3; i++) begin
        p  = (m_ptr + i) % 3;
        el = (p == 0) ? (ifetch_read_req && !full) :
             (p == 1) ? (load_read_req && !full) : store_write_req;
        if (el && e_grant < 0) e_grant = p;
      end
    end
    e_accept = (e_grant >= 0) && mem_ready;
    e_pop    = reset_n && mem_read_data_valid && (m_q.size() > 0);
    e_head   = e_pop ? m_q[0] : -1;
    a = '0; wd = '0; be = '0; rr = 0; wr = 0;
    case (e_grant)
      0: begin a = ifetch_read_addr; be = 4'hf; rr = 1; end
      1: begin a = load_read_addr;   be = 4'hf; rr = 1; end
      2: begin a = store_addr; wd = store_write_data; be = store_byte_enable; wr = 1; end
      default: ;
    endcase
    exp_v = {e_accept && e_grant == 0, e_accept && e_grant == 1, e_accept && e_grant == 2,
             rr, wr, a, wd, be, e_head == 0, e_head == 1,
             mem_read_data, mem_read_data, m_err && reset_n};
  endtask

  task automatic commit_model();
    if (!reset_n) begin
      m_q.delete();
      m_ptr = 0;
      m_err = 0;
    end else begin
      if (mem_read_data_valid && m_q.size() == 0) m_err = 1;
      if (e_pop) void'(m_q.pop_front());
      if (e_accept) begin
        if (e_grant < 2) m_q.push_back(e_grant);
        m_ptr = (e_grant + 1) % 3;
      end
    end
  endtask

  task automatic settle();
    #1;
    eval_model();
  endtask

  task automatic next_cycle();
    @(posedge clk);
    commit_model();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    ifetch_read_req = 0; load_read_req = 0; store_write_req = 0;
    ifetch_read_addr = '0; load_read_addr = '0; store_addr = '0;
    store_write_data = '0; store_byte_enable = '0;
    mem_ready = 0; mem_read_data_valid = 0; mem_read_data = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset_n = 0;
    settle();
    next_cycle();
    reset_n = 1;
  endtask

  task automatic test_reset();
    clear_inputs();
    reset_n = 0;
    ifetch_read_req = 1; load_read_req = 1; store_write_req = 1;
    ifetch_read_addr = 32'h10; load_read_addr = 32'h20; store_addr = 32'h30;
    store_write_data = 32'h1234; store_byte_enable = 4'h3;
    mem_ready = 1; mem_read_data_valid = 1;
    for (int c = 0; c < 2; c++) begin
      settle();
      n_checks++;
      if (obs !== '0) begin
        n_fail++;
        $display("FAIL reset_outputs c%0d: got %h expected 0", c, obs);
      end
      next_cycle();
    end
    clear_inputs();
    reset_n = 1;
  endtask

  task automatic test_single_load();
    do_reset();
    load_read_req = 1; load_read_addr = 32'h100; mem_ready = 1;
    settle();
    n_checks++;
    if ({ifetch_ready, load_ready, store_ready, mem_read_req, mem_byte_enable} !== 8'b010_1_1111) begin
      n_fail++;
      $display("FAIL single_load_grant: got %b expected 01011111",
               {ifetch_ready, load_ready, store_ready, mem_read_req, mem_byte_enable});
    end
    n_checks++;
    if (mem_addr !== 32'h100) begin
      n_fail++;
      $display("FAIL single_load_addr: got %h expected 00000100", mem_addr);
    end
    next_cycle();
    load_read_req = 0;
    for (int c = 1; c < 3; c++) begin
      settle();
      n_checks++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL single_load_wait c%0d: got %h expected %h", c, obs, exp_v);
      end
      next_cycle();
    end
    mem_read_data_valid = 1; mem_read_data = 32'hdeadbeef;
    settle();
    n_checks++;
    if ({load_read_data_valid, ifetch_read_data_valid, load_read_data} !== {2'b10, 32'hdeadbeef}) begin
      n_fail++;
      $display("FAIL single_load_return: got %b %b %h expected 1 0 deadbeef",
               load_read_data_valid, ifetch_read_data_valid, load_read_data);
    end
    next_cycle();
    clear_inputs();
  endtask

  task automatic test_round_robin();
    int seq[6];
    int got;
    seq = '{0, 1, 2, 0, 1, 2};
    do_reset();
    ifetch_read_req = 1; load_read_req = 1; store_write_req = 1; mem_ready = 1;
    ifetch_read_addr = 32'h1000; load_read_addr = 32'h2000; store_addr = 32'h3000;
    store_write_data = 32'hcafef00d; store_byte_enable = 4'h5;
    for (int c = 0; c < 6; c++) begin
      settle();
      got = ifetch_ready ? 0 : load_ready ? 1 : store_ready ? 2 : -1;
      n_checks++;
      if (got !== seq[c]) begin
        n_fail++;
        $display("FAIL round_robin_grant c%0d: got %0d expected %0d", c, got, seq[c]);
      end
      if (seq[c] == 2) begin
        n_checks++;
        if ({mem_write_req, mem_byte_enable, mem_write_data} !== {1'b1, 4'h5, 32'hcafef00d}) begin
          n_fail++;
          $display("FAIL round_robin_store c%0d: got %b %h %h expected 1 5 cafef00d",
                   c, mem_write_req, mem_byte_enable, mem_write_data);
        end
      end
      n_checks++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL round_robin_vec c%0d: got %h expected %h", c, obs, exp_v);
      end
      next_cycle();
    end
    clear_inputs();
  endtask

  task automatic test_in_order_return();
    do_reset();
    ifetch_read_req = 1; ifetch_read_addr = 32'h0; mem_ready = 1;
    settle();
    n_checks++;
    if ({ifetch_ready, mem_addr} !== {1'b1, 32'h0}) begin
      n_fail++;
      $display("FAIL in_order_fetch: got %b %h expected 1 00000000", ifetch_ready, mem_addr);
    end
    next_cycle();
    ifetch_read_req = 0; load_read_req = 1; load_read_addr = 32'h4;
    settle();
    n_checks++;
    if ({load_ready, mem_addr} !== {1'b1, 32'h4}) begin
      n_fail++;
      $display("FAIL in_order_load: got %b %h expected 1 00000004", load_ready, mem_addr);
    end
    next_cycle();
    load_read_req = 0; mem_read_data_valid = 1; mem_read_data = 32'h11;
    settle();
    n_checks++;
    if ({ifetch_read_data_valid, load_read_data_valid, ifetch_read_data} !== {2'b10, 32'h11}) begin
      n_fail++;
      $display("FAIL in_order_ret0: got %b %b %h expected 1 0 00000011",
               ifetch_read_data_valid, load_read_data_valid, ifetch_read_data);
    end
    next_cycle();
    mem_read_data = 32'h22;
    settle();
    n_checks++;
    if ({ifetch_read_data_valid, load_read_data_valid, load_read_data} !== {2'b01, 32'h22}) begin
      n_fail++;
      $display("FAIL in_order_ret1: got %b %b %h expected 0 1 00000022",
               ifetch_read_data_valid, load_read_data_valid, load_read_data);
    end
    next_cycle();
    clear_inputs();
  endtask

  task automatic test_full_queue();
    int n_acc = 0;
    do_reset();
    ifetch_read_req = 1; load_read_req = 1; mem_ready = 1;
    ifetch_read_addr = 32'h500; load_read_addr = 32'h600;
    for (int c = 0; c < 6; c++) begin
      settle();
      n_acc += int'(ifetch_ready) + int'(load_ready);
      n_checks++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL full_fill_vec c%0d: got %h expected %h", c, obs, exp_v);
      end
      next_cycle();
    end
    n_checks++;
    if (n_acc !== DEPTH) begin
      n_fail++;
      $display("FAIL full_accept_count: got %0d expected %0d", n_acc, DEPTH);
    end
    store_write_req = 1; store_addr = 32'h700; store_byte_enable = 4'hc;
    settle();
    n_checks++;
    if ({ifetch_ready, load_ready, store_ready} !== 3'b001) begin
      n_fail++;
      $display("FAIL full_store_wins: got %b expected 001", {ifetch_ready, load_ready, store_ready});
    end
    next_cycle();
    store_write_req = 0; mem_read_data_valid = 1; mem_read_data = 32'haa;
    settle();
    n_checks++;
    if ({ifetch_ready, load_ready, ifetch_read_data_valid} !== 3'b001) begin
      n_fail++;
      $display("FAIL full_pop_no_push: got %b expected 001",
               {ifetch_ready, load_ready, ifetch_read_data_valid});
    end
    next_cycle();
    mem_read_data_valid = 0;
    settle();
    n_checks++;
    if ({ifetch_ready, load_ready} !== 2'b10) begin
      n_fail++;
      $display("FAIL full_after_pop: got %b expected 10", {ifetch_ready, load_ready});
    end
    next_cycle();
    clear_inputs();
  endtask

  task automatic test_stall();
    do_reset();
    load_read_req = 1; load_read_addr = 32'h80; mem_ready = 1;
    settle();
    n_checks++;
    if (load_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL stall_setup: got %b expected 1", load_ready);
    end
    next_cycle();
    ifetch_read_req = 1; store_write_req = 1; mem_ready = 0;
    ifetch_read_addr = 32'h40; store_addr = 32'hc0; store_byte_enable = 4'hf;
    for (int c = 0; c < 5; c++) begin
      settle();
      n_checks++;
      if ({ifetch_ready, load_ready, store_ready, mem_write_req, mem_addr} !== {4'b0001, 32'hc0}) begin
        n_fail++;
        $display("FAIL stall_hold c%0d: got %b %h expected 0001 000000c0", c,
                 {ifetch_ready, load_ready, store_ready, mem_write_req}, mem_addr);
      end
      next_cycle();
    end
    store_write_req = 0;
    settle();
    n_checks++;
    if ({mem_read_req, mem_write_req, mem_addr} !== {2'b10, 32'h40}) begin
      n_fail++;
      $display("FAIL stall_regrant: got %b %b %h expected 1 0 00000040",
               mem_read_req, mem_write_req, mem_addr);
    end
    next_cycle();
    clear_inputs();
  endtask

  task automatic test_error_reset();
    do_reset();
    mem_read_data_valid = 1; mem_read_data = 32'h55;
    settle();
    n_checks++;
    if ({ifetch_read_data_valid, load_read_data_valid, error} !== 3'b000) begin
      n_fail++;
      $display("FAIL err_no_forward: got %b expected 000",
               {ifetch_read_data_valid, load_read_data_valid, error});
    end
    next_cycle();
    mem_read_data_valid = 0;
    for (int c = 0; c < 3; c++) begin
      settle();
      n_checks++;
      if (error !== 1'b1) begin
        n_fail++;
        $display("FAIL err_sticky c%0d: got %b expected 1", c, error);
      end
      next_cycle();
    end
    load_read_req = 1; mem_ready = 1;
    settle();
    next_cycle();
    clear_inputs();
    reset_n = 0;
    settle();
    n_checks++;
    if (error !== 1'b0) begin
      n_fail++;
      $display("FAIL err_in_reset: got %b expected 0", error);
    end
    next_cycle();
    reset_n = 1;
    ifetch_read_req = 1; load_read_req = 1; store_write_req = 1; mem_ready = 1;
    mem_read_data_valid = 1;
    settle();
    n_checks++;
    if ({error, ifetch_ready, load_read_data_valid, ifetch_read_data_valid} !== 4'b0100) begin
      n_fail++;
      $display("FAIL err_after_reset: got %b expected 0100",
               {error, ifetch_ready, load_read_data_valid, ifetch_read_data_valid});
    end
    next_cycle();
    clear_inputs();
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      ifetch_read_req     = 1'($urandom_range(0, 1));
      load_read_req       = 1'($urandom_range(0, 1));
      store_write_req     = 1'($urandom_range(0, 1));
      ifetch_read_addr    = $urandom & 32'hffff_fffc;
      load_read_addr      = $urandom & 32'hffff_fffc;
      store_addr          = $urandom & 32'hffff_fffc;
      store_write_data    = $urandom;
      store_byte_enable   = 4'($urandom);
      mem_ready           = ($urandom_range(0, 3) != 0);
      mem_read_data       = $urandom;
      mem_read_data_valid = (m_q.size() > 0 && $urandom_range(0, 1) == 1) ||
                            ($urandom_range(0, 63) == 0);
      settle();
      n_checks++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL random_vec c%0d: got %h expected %h", c, obs, exp_v);
      end
      next_cycle();
    end
    clear_inputs();
  endtask

  initial begin
    m_ptr = 0;
    m_err = 0;
    test_reset();
    test_single_load();
    test_round_robin();
    test_in_order_return();
    test_full_queue();
    test_stall();
    test_error_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
